// File: rtl/core_alu_arb.sv
// core_alu_arb: two-port arbiter/sequencer for one shared combinational ALU.
// Ports: req0_*/req1_* requests, alu_* shared ALU drive/return, rsp_* response.
module core_alu_arb #(
  parameter int XLEN         = 32,
  parameter int PRIO_MODE    = 0,
  parameter int STARVE_LIMIT = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_src1,
  input  logic [XLEN-1:0] req0_src2,
  input  logic [3:0]      req0_alu_op,
  input  logic [2:0]      req0_brnch_cnd,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_src1,
  input  logic [XLEN-1:0] req1_src2,
  input  logic [3:0]      req1_alu_op,
  input  logic [2:0]      req1_brnch_cnd,
  output logic [XLEN-1:0] alu_src1,
  output logic [XLEN-1:0] alu_src2,
  output logic [3:0]      alu_op,
  output logic [2:0]      alu_brnch_cnd,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_brnch_takenn,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [XLEN-1:0] rsp_result,
  output logic            rsp_taken
);

  localparam logic [7:0] SLIM = 8'(STARVE_LIMIT);

  logic       out_free;
  logic       grant0;
  logic       grant1;
  logic       accept;
  logic       rr_last;
  logic [7:0] starve_cnt;

  // Response slot is free if empty or being drained this cycle.
  assign out_free = !rsp_valid || rsp_ready;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (out_free) begin
      if (req0_valid && req1_valid) begin
        if (PRIO_MODE == 0) begin
          // rr_last=1 means port 1 went last, so port 0 wins.
          grant0 = rr_last;
          grant1 = !rr_last;
        end else begin
          grant1 = (starve_cnt == SLIM);
          grant0 = !grant1;
        end
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept     = grant0 || grant1;

  always_comb begin
    alu_src1      = '0;
    alu_src2      = '0;
    alu_op        = '0;
    alu_brnch_cnd = '0;
    unique case (1'b1)
      grant0: begin
        alu_src1      = req0_src1;
        alu_src2      = req0_src2;
        alu_op        = req0_alu_op;
        alu_brnch_cnd = req0_brnch_cnd;
      end
      grant1: begin
        alu_src1      = req1_src1;
        alu_src2      = req1_src2;
        alu_op        = req1_alu_op;
        alu_brnch_cnd = req1_brnch_cnd;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_taken  <= 1'b0;
      rr_last    <= 1'b1;
    end else if (accept) begin
      rsp_valid  <= 1'b1;
      rsp_id     <= grant1;
      rsp_result <= alu_result;
      rsp_taken  <= alu_brnch_takenn;
      rr_last    <= grant1;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

  // Counts cycles port 1 waits while valid; saturates at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (PRIO_MODE == 0) begin
      starve_cnt <= '0;
    end else if (req1_valid && !grant1) begin
      if (starve_cnt < SLIM) begin
        starve_cnt <= starve_cnt + 8'd1;
      end
    end else begin
      starve_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_core_alu_arb.sv
// tb_core_alu_arb: scoreboard bench for core_alu_arb in round-robin
// (dut a) and fixed-priority STARVE_LIMIT=4 (dut b) configurations.
module tb_core_alu_arb;

  localparam logic [3:0] ADD = 4'd0;
  localparam logic [3:0] SUB = 4'd1;
  localparam logic [2:0] BEQ = 3'b100;

  typedef struct {
    logic        id;
    logic [31:0] res;
    logic        tk;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_v0, a_r0, a_v1, a_r1;
  logic [31:0] a_s01, a_s02, a_s11, a_s12;
  logic [3:0]  a_op0, a_op1;
  logic [2:0]  a_c0, a_c1;
  logic [31:0] a_as1, a_as2, a_ares;
  logic [3:0]  a_aop;
  logic [2:0]  a_acnd;
  logic        a_atk;
  logic        a_rv, a_rr, a_rid, a_rtk;
  logic [31:0] a_rres;

  logic        b_v0, b_r0, b_v1, b_r1;
  logic [31:0] b_as1, b_as2, b_ares;
  logic [3:0]  b_aop;
  logic [2:0]  b_acnd;
  logic        b_atk;
  logic        b_rv, b_rr, b_rid, b_rtk;
  logic [31:0] b_rres;

  function automatic logic [31:0] alu_f(logic [3:0] op,
                                        logic [31:0] x,
                                        logic [31:0] y);
    case (op)
      ADD:     return x + y;
      SUB:     return x - y;
      default: return x ^ y;
    endcase
  endfunction

  function automatic logic br_f(logic [2:0] c,
                                logic [31:0] x,
                                logic [31:0] y);
    if (c == BEQ) return x == y;
    if (c == 3'b101) return x != y;
    return 1'b0;
  endfunction

  always_comb begin
    a_ares = alu_f(a_aop, a_as1, a_as2);
    a_atk  = br_f(a_acnd, a_as1, a_as2);
    b_ares = alu_f(b_aop, b_as1, b_as2);
    b_atk  = br_f(b_acnd, b_as1, b_as2);
  end

  core_alu_arb #(.XLEN(32), .PRIO_MODE(0)) u_a (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(a_v0), .req0_ready(a_r0),
    .req0_src1(a_s01), .req0_src2(a_s02),
    .req0_alu_op(a_op0), .req0_brnch_cnd(a_c0),
    .req1_valid(a_v1), .req1_ready(a_r1),
    .req1_src1(a_s11), .req1_src2(a_s12),
    .req1_alu_op(a_op1), .req1_brnch_cnd(a_c1),
    .alu_src1(a_as1), .alu_src2(a_as2),
    .alu_op(a_aop), .alu_brnch_cnd(a_acnd),
    .alu_result(a_ares), .alu_brnch_takenn(a_atk),
    .rsp_valid(a_rv), .rsp_ready(a_rr), .rsp_id(a_rid),
    .rsp_result(a_rres), .rsp_taken(a_rtk)
  );

  core_alu_arb #(.XLEN(32), .PRIO_MODE(1), .STARVE_LIMIT(4)) u_b (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(b_v0), .req0_ready(b_r0),
    .req0_src1(32'd1), .req0_src2(32'd1),
    .req0_alu_op(ADD), .req0_brnch_cnd(3'b000),
    .req1_valid(b_v1), .req1_ready(b_r1),
    .req1_src1(32'd10), .req1_src2(32'd10),
    .req1_alu_op(ADD), .req1_brnch_cnd(3'b000),
    .alu_src1(b_as1), .alu_src2(b_as2),
    .alu_op(b_aop), .alu_brnch_cnd(b_acnd),
    .alu_result(b_ares), .alu_brnch_takenn(b_atk),
    .rsp_valid(b_rv), .rsp_ready(b_rr), .rsp_id(b_rid),
    .rsp_result(b_rres), .rsp_taken(b_rtk)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && a_rv && a_rr) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_rsp_id", {31'd0, a_rid}, {31'd0, e.id});
        chk("a_rsp_result", a_rres, e.res);
        chk("a_rsp_taken", {31'd0, a_rtk}, {31'd0, e.tk});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_rv && b_rr) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = qb.pop_front();
        chk("b_rsp_id", {31'd0, b_rid}, {31'd0, e.id});
        chk("b_rsp_result", b_rres, e.res);
        chk("b_rsp_taken", {31'd0, b_rtk}, {31'd0, e.tk});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input logic v0, input logic v1, input logic rdy);
    a_v0 = v0;
    a_v1 = v1;
    a_rr = rdy;
  endtask

  task automatic rdy_a(input string nm, input logic e0, input logic e1);
    chk({nm, "_r0"}, {31'd0, a_r0}, {31'd0, e0});
    chk({nm, "_r1"}, {31'd0, a_r1}, {31'd0, e1});
  endtask

  task automatic idle();
    step();
    drv_a(1'b0, 1'b0, 1'b1);
    b_v0 = 1'b0;
    b_v1 = 1'b0;
    b_rr = 1'b1;
    @(negedge clk);
  endtask

  task automatic push(inout exp_t q[$], input logic id,
                      input logic [31:0] res, input logic tk);
    exp_t e;
    e.id  = id;
    e.res = res;
    e.tk  = tk;
    q.push_back(e);
  endtask

  initial begin
    drv_a(1'b0, 1'b0, 1'b1);
    a_s01 = 32'd1;  a_s02 = 32'd1;  a_op0 = ADD; a_c0 = 3'b000;
    a_s11 = 32'd10; a_s12 = 32'd10; a_op1 = ADD; a_c1 = 3'b000;
    b_v0 = 1'b0; b_v1 = 1'b0; b_rr = 1'b1;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", {31'd0, a_rv}, 32'd0);
    chk("rst_rsp_id", {31'd0, a_rid}, 32'd0);
    chk("rst_rsp_result", a_rres, 32'd0);
    chk("rst_rsp_taken", {31'd0, a_rtk}, 32'd0);
    chk("rst_b_rsp_valid", {31'd0, b_rv}, 32'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", {30'd0, a_r0, a_r1}, 32'd0);
    chk("idle_alu_src1", a_as1, 32'd0);

    // Round-robin stream: 0,1,0,1 with no bubbles.
    push(qa, 1'b0, 32'd2, 1'b0);
    push(qa, 1'b1, 32'd20, 1'b0);
    push(qa, 1'b0, 32'd2, 1'b0);
    push(qa, 1'b1, 32'd20, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      drv_a(1'b1, 1'b1, 1'b1);
      @(negedge clk);
      rdy_a("rr", (i % 2) == 0, (i % 2) == 1);
    end
    idle();

    // Port 0 alone: 5 + 7.
    a_s01 = 32'd5;
    a_s02 = 32'd7;
    push(qa, 1'b0, 32'd12, 1'b0);
    step();
    drv_a(1'b1, 1'b0, 1'b1);
    @(negedge clk);
    rdy_a("p0only", 1'b1, 1'b0);
    chk("p0only_alu_src2", a_as2, 32'd7);
    idle();
    idle();

    // Backpressure: port 1 wins, response stalls 3 cycles.
    a_s01 = 32'd1;
    a_s02 = 32'd1;
    push(qa, 1'b1, 32'd20, 1'b0);
    push(qa, 1'b0, 32'd2, 1'b0);
    step();
    drv_a(1'b1, 1'b1, 1'b1);
    @(negedge clk);
    rdy_a("bp_first", 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      drv_a(1'b1, 1'b1, 1'b0);
      @(negedge clk);
      rdy_a("bp_stall", 1'b0, 1'b0);
      chk("bp_rsp_valid", {31'd0, a_rv}, 32'd1);
      chk("bp_rsp_id", {31'd0, a_rid}, 32'd1);
      chk("bp_rsp_result", a_rres, 32'd20);
    end
    step();
    drv_a(1'b1, 1'b1, 1'b1);
    @(negedge clk);
    rdy_a("bp_release", 1'b1, 1'b0);
    idle();
    idle();

    // Branch on port 1: equal then unequal operands.
    a_op1 = SUB;
    a_c1  = BEQ;
    a_s11 = 32'h1234;
    a_s12 = 32'h1234;
    push(qa, 1'b1, 32'd0, 1'b1);
    push(qa, 1'b1, 32'hFFFF_FFFF, 1'b0);
    step();
    drv_a(1'b0, 1'b1, 1'b1);
    @(negedge clk);
    rdy_a("beq_eq", 1'b0, 1'b1);
    chk("beq_alu_cnd", {29'd0, a_acnd}, {29'd0, BEQ});
    step();
    a_s12 = 32'h1235;
    @(negedge clk);
    rdy_a("beq_ne", 1'b0, 1'b1);
    idle();
    idle();
    a_op1 = ADD;
    a_c1  = 3'b000;
    a_s11 = 32'd10;
    a_s12 = 32'd10;

    // Fixed priority with starvation guard at 4.
    for (int i = 0; i < 10; i++) begin
      if ((i % 5) == 4) push(qb, 1'b1, 32'd20, 1'b0);
      else              push(qb, 1'b0, 32'd2, 1'b0);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      b_v0 = 1'b1;
      b_v1 = 1'b1;
      b_rr = 1'b1;
      @(negedge clk);
      chk("fp_r0", {31'd0, b_r0}, {31'd0, (i % 5) != 4});
      chk("fp_r1", {31'd0, b_r1}, {31'd0, (i % 5) == 4});
    end
    idle();
    idle();

    // Reset while a response is stalled.
    a_s01 = 32'd5;
    a_s02 = 32'd7;
    step();
    drv_a(1'b1, 1'b0, 1'b1);
    @(negedge clk);
    rdy_a("rst_fill", 1'b1, 1'b0);
    step();
    drv_a(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("rst_pre_valid", {31'd0, a_rv}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", {31'd0, a_rv}, 32'd0);
    chk("rst_async_result", a_rres, 32'd0);
    push(qa, 1'b0, 32'd12, 1'b0);
    step();
    rst_n = 1'b1;
    drv_a(1'b1, 1'b1, 1'b1);
    @(negedge clk);
    rdy_a("rst_after", 1'b1, 1'b0);
    idle();
    idle();

    chk("qa_empty", qa.size(), 32'd0);
    chk("qb_empty", qb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
